// File: rtl/arkkotanjant_if.sv
// Handshake bundle for the arc-cotangent unit: start/operand in, ready/result/valid/saturation out.
interface arkkotanjant_if;
  logic        basla;
  logic [31:0] deger;
  logic        hazir;
  logic [31:0] sonuc;
  logic        gecerli;
  logic        tasma;

  modport master (output basla, deger, input hazir, sonuc, gecerli, tasma);
  modport slave  (input basla, deger, output hazir, sonuc, gecerli, tasma);
endinterface

// File: rtl/arkkotanjant.sv
// Iterative CORDIC (vectoring) arc-cotangent: signed Q16.16 in, Q16.16 radians 0..pi out.
// Optional macro ARKKOTANJANT_HIZLI_SIFIR_EN: a zero operand returns pi/2 one cycle after acceptance.
//
// state  | meaning
// BOS    | idle, hazir=1, waiting for basla
// DONGU  | one CORDIC iteration per clock
// DUZELT | quadrant correction, result/valid output
module arkkotanjant #(
  parameter int ITER = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  arkkotanjant_if.slave bus
);

  localparam logic [1:0] BOS    = 2'd0;
  localparam logic [1:0] DONGU  = 2'd1;
  localparam logic [1:0] DUZELT = 2'd2;
  localparam logic signed [31:0] PI_Q = 32'sd205887;
`ifdef ARKKOTANJANT_HIZLI_SIFIR_EN
  localparam logic signed [31:0] PI_2_Q = 32'sd102944;
`endif

  logic [1:0]         state_q, state_d;
  logic signed [33:0] x_q, x_d, y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic [4:0]         i_q, i_d;
  logic               neg_q, neg_d, sat_q, sat_d;
  logic [31:0]        sonuc_q, sonuc_d;
  logic               gecerli_q, gecerli_d, tasma_q, tasma_d;

  logic [31:0]        mag;
  logic signed [33:0] x_sh, y_sh;
  logic signed [31:0] t_i;

  function automatic logic signed [31:0] aci(input logic [4:0] k);
    case (k)
      5'd0:    aci = 32'sd51472;
      5'd1:    aci = 32'sd30386;
      5'd2:    aci = 32'sd16055;
      5'd3:    aci = 32'sd8150;
      5'd4:    aci = 32'sd4091;
      5'd5:    aci = 32'sd2047;
      5'd6:    aci = 32'sd1024;
      5'd7:    aci = 32'sd512;
      5'd8:    aci = 32'sd256;
      5'd9:    aci = 32'sd128;
      5'd10:   aci = 32'sd64;
      5'd11:   aci = 32'sd32;
      5'd12:   aci = 32'sd16;
      5'd13:   aci = 32'sd8;
      5'd14:   aci = 32'sd4;
      5'd15:   aci = 32'sd2;
      5'd16:   aci = 32'sd1;
      default: aci = 32'sd0;
    endcase
  endfunction

  // |deger|, with the most negative operand clamped to the largest positive value
  always_comb begin
    mag = bus.deger[31] ? (32'd0 - bus.deger) : bus.deger;
    if (bus.deger == 32'h8000_0000) mag = 32'h7FFF_FFFF;
  end

  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;
  assign t_i  = aci(i_q);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    i_d       = i_q;
    neg_d     = neg_q;
    sat_d     = sat_q;
    sonuc_d   = sonuc_q;
    tasma_d   = tasma_q;
    gecerli_d = 1'b0;
    case (state_q)
      BOS: begin
        if (bus.basla) begin
          neg_d   = bus.deger[31];
          sat_d   = (bus.deger == 32'h8000_0000);
          x_d     = {2'b00, mag};
          y_d     = 34'sd65536;
          z_d     = '0;
          i_d     = '0;
          state_d = DONGU;
`ifdef ARKKOTANJANT_HIZLI_SIFIR_EN
          if (bus.deger == 32'h0) begin
            z_d     = PI_2_Q;
            state_d = DUZELT;
          end
`endif
        end
      end
      DONGU: begin
        // drive y toward zero; z accumulates atan(y0/x0) = arccot(|x|)
        if (!y_q[33]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + t_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - t_i;
        end
        i_d = i_q + 5'd1;
        if (i_q == 5'(ITER - 1)) state_d = DUZELT;
      end
      DUZELT: begin
        sonuc_d   = neg_q ? 32'(PI_Q - z_q) : 32'(z_q);
        tasma_d   = sat_q;
        gecerli_d = 1'b1;
        state_d   = BOS;
      end
      default: state_d = BOS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOS;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      i_q       <= '0;
      neg_q     <= 1'b0;
      sat_q     <= 1'b0;
      sonuc_q   <= '0;
      gecerli_q <= 1'b0;
      tasma_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      i_q       <= i_d;
      neg_q     <= neg_d;
      sat_q     <= sat_d;
      sonuc_q   <= sonuc_d;
      gecerli_q <= gecerli_d;
      tasma_q   <= tasma_d;
    end
  end

  assign bus.hazir   = (state_q == BOS);
  assign bus.sonuc   = sonuc_q;
  assign bus.gecerli = gecerli_q;
  assign bus.tasma   = tasma_q;

endmodule

// File: tb/tb_arkkotanjant.sv
// Randomized self-checking bench for arkkotanjant against a real-arithmetic arccot model.
module tb_arkkotanjant;
  localparam int ITER = 16;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  arkkotanjant_if bus ();

  arkkotanjant #(.ITER(ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint d;
    n_checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // arccot(x) = atan2(1, x) lies in (0, pi); most negative operand uses the saturated magnitude
  function automatic longint model_arccot(input logic [31:0] v);
    int  s;
    real xr;
    s = int'(v);
    if (v == 32'h8000_0000) s = -2147483647;
    xr = real'(s) / 65536.0;
    return longint'($atan2(1.0, xr) * 65536.0);
  endfunction

  function automatic int model_lat(input logic [31:0] v);
`ifdef ARKKOTANJANT_HIZLI_SIFIR_EN
    if (v == 32'h0) return 1;
`endif
    return ITER + 1;
  endfunction

  function automatic int model_tol(input logic [31:0] v);
`ifdef ARKKOTANJANT_HIZLI_SIFIR_EN
    if (v == 32'h0) return 0;
`endif
    return 8;
  endfunction

  // one operation; dist_at >= 0 pulses basla (deger=3.0) that many cycles after acceptance
  task automatic do_op(input logic [31:0] v, input int dist_at);
    int          lat;
    int          extra;
    bit          got;
    logic [31:0] held;
    @(negedge clk);
    check("hazir_idle", bus.hazir, 1, 0);
    bus.basla = 1'b1;
    bus.deger = v;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      bus.basla = (lat == dist_at);
      bus.deger = (lat == dist_at) ? 32'h0003_0000 : $urandom;
      if (lat == 1 && model_lat(v) > 1) check("hazir_busy", bus.hazir, 0, 0);
      if (bus.gecerli) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    bus.basla = 1'b0;
    check("gecerli_seen", got, 1, 0);
    check("latency", lat, model_lat(v), 0);
    check("sonuc", bus.sonuc, model_arccot(v), model_tol(v));
    check("tasma", bus.tasma, (v == 32'h8000_0000), 0);
    check("hazir_done", bus.hazir, 1, 0);
    held = bus.sonuc;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.gecerli) extra++;
    end
    check("gecerli_once", extra, 0, 0);
    check("sonuc_hold", bus.sonuc, held, 0);
  endtask

  initial begin
    logic [31:0] v;
    int          s;
    int          pulses;
    logic [31:0] dir_tab[8] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000,
                                 32'h0002_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    bus.basla = 1'b0;
    bus.deger = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hazir", bus.hazir, 1, 0);
    check("rst_gecerli", bus.gecerli, 0, 0);
    check("rst_sonuc", bus.sonuc, 0, 0);
    check("rst_tasma", bus.tasma, 0, 0);
    rst_n = 1'b1;

    foreach (dir_tab[k]) do_op(dir_tab[k], -1);

    // async reset between edges after a saturated result
    do_op(32'h8000_0000, -1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_hazir", bus.hazir, 1, 0);
    check("arst_gecerli", bus.gecerli, 0, 0);
    check("arst_sonuc", bus.sonuc, 0, 0);
    check("arst_tasma", bus.tasma, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // busy: second basla during iteration is ignored
    do_op(32'h0001_0000, 5);

    // abort mid-iteration
    @(negedge clk);
    do_op(32'h0002_0000, -1);
    @(negedge clk);
    bus.basla = 1'b1;
    bus.deger = 32'h0001_0000;
    @(posedge clk);
    #1 bus.basla = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_hazir", bus.hazir, 1, 0);
    check("abort_gecerli", bus.gecerli, 0, 0);
    check("abort_sonuc", bus.sonuc, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.gecerli) pulses++;
    end
    check("abort_no_valid", pulses, 0, 0);
    do_op(32'h0001_0000, -1);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 2))
        0: v = $urandom;
        1: begin
          s = int'($urandom_range(0, 1048576)) - 524288;
          v = s;
        end
        default: begin
          s = int'($urandom_range(0, 2046)) - 1023;
          v = s;
        end
      endcase
      do_op(v, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end
endmodule
